// File: rtl/pixel_array_receiver.sv
// Consumer end of the pixel-array output bus: edge-detects the data strobe, buffers
// captured bus words in a small FIFO and unpacks them into a tagged one-pixel-per-beat stream.
module pixel_array_receiver #(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 8,
  parameter int FIFO_DEPTH             = 4
) (
  input  logic                                        SYSTEM_CLK,
  input  logic                                        READ_RESET,
  input  logic                                        FRAME_START,
  input  logic                                        DATA_IN_CLK,
  input  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_IN,
  output logic [BIT_DEPTH-1:0]                        PIXEL_OUT,
  output logic                                        PIXEL_VALID,
  input  logic                                        PIXEL_READY,
  output logic [$clog2(HEIGHT):0]                     PIXEL_ROW,
  output logic [$clog2(WIDTH):0]                      PIXEL_COL,
  output logic                                        FRAME_DONE,
  output logic                                        OVERFLOW,
  output logic                                        BUSY
);

  localparam int BUS_W       = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
  localparam int TOTAL_WORDS = WIDTH * HEIGHT / OUTPUT_BUS_PIXEL_WIDTH;
  localparam int ROW_W       = $clog2(HEIGHT) + 1;
  localparam int COL_W       = $clog2(WIDTH) + 1;
  localparam int PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W       = PTR_W + 1;
  localparam int WC_W        = $clog2(TOTAL_WORDS + 1);
  localparam int LANE_W      = (OUTPUT_BUS_PIXEL_WIDTH > 1) ? $clog2(OUTPUT_BUS_PIXEL_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    DONE
  } state_t;

  state_t state, state_next;

  logic                strobe_q;
  logic [BUS_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [WC_W-1:0]     words_captured;
  logic [BUS_W-1:0]    word_q;
  logic [LANE_W-1:0]   lane;
  logic                valid_q;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic                overflow_q;

  logic receiving, edge_seen, frame_open, fifo_full, fifo_empty;
  logic xfer, last_lane, last_pixel, pop, push, drop;

  assign receiving  = (state == RECEIVE);
  assign edge_seen  = DATA_IN_CLK && !strobe_q;
  assign frame_open = (words_captured < WC_W'(TOTAL_WORDS));
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign xfer       = valid_q && PIXEL_READY;
  assign last_lane  = (lane == LANE_W'(OUTPUT_BUS_PIXEL_WIDTH - 1));
  assign last_pixel = receiving && xfer &&
                      (row == ROW_W'(HEIGHT - 1)) && (col == COL_W'(WIDTH - 1));

  // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
  assign pop  = receiving && !fifo_empty && (!valid_q || (xfer && last_lane));
  assign push = receiving && edge_seen && frame_open && (!fifo_full || pop);
  assign drop = receiving && edge_seen && frame_open && fifo_full && !pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge SYSTEM_CLK) begin
    if (READ_RESET) begin
      strobe_q <= 1'b0;
      state    <= IDLE;
    end else begin
      strobe_q <= DATA_IN_CLK;
      state    <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (FRAME_START) begin
      state_next = RECEIVE;
    end else begin
      unique case (state)
        IDLE:    state_next = IDLE;
        RECEIVE: if (last_pixel) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define what is valid.
  always_ff @(posedge SYSTEM_CLK) begin
    if (push) fifo_mem[wr_ptr] <= DATA_IN;
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (READ_RESET || FRAME_START) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      words_captured <= '0;
      overflow_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + 1'b1;
        words_captured <= words_captured + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Unpacker shifts the held word down one lane per accepted beat; lane 0 is always on PIXEL_OUT.
  always_ff @(posedge SYSTEM_CLK) begin
    if (READ_RESET || FRAME_START) begin
      word_q  <= '0;
      lane    <= '0;
      valid_q <= 1'b0;
      row     <= '0;
      col     <= '0;
    end else begin
      if (pop) begin
        word_q  <= fifo_mem[rd_ptr];
        lane    <= '0;
        valid_q <= 1'b1;
      end else if (xfer) begin
        if (last_lane) begin
          valid_q <= 1'b0;
        end else begin
          word_q <= word_q >> BIT_DEPTH;
          lane   <= lane + 1'b1;
        end
      end
      if (xfer) begin
        if (col == COL_W'(WIDTH - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign PIXEL_OUT   = word_q[BIT_DEPTH-1:0];
  assign PIXEL_VALID = valid_q;
  assign PIXEL_ROW   = row;
  assign PIXEL_COL   = col;
  assign FRAME_DONE  = (state == DONE);
  assign OVERFLOW    = overflow_q;
  assign BUSY        = receiving;

endmodule
